fault_campaign_ctrl: RTL and testbench
======================================

// Module: fault_campaign_ctrl
// PURPOSE
// Hardware fault-injection sequencer driving the exp10_top_part2 fault interface (fault_en, fault_bit).
// On start it captures one fault-free reference ciphertext.
// It then steps fault_bit through 0..NUM_BITS-1, waits a settle window for each bit, captures the faulty ciphertext and streams it out.
// The stream uses a valid/ready handshake and feeds the DFA result buffer / UART dumper on-chip.
// PARAMETERS
// NUM_BITS         128  number of fault positions swept, 1..128; fault_bit = 0..NUM_BITS-1
// BASELINE_CYCLES  100  clocks with fault_en=0 before the reference capture, >=1
// SETTLE_CYCLES    20   clocks each fault_bit is held before capture, >=1
// PORTS
// clk         in   1    system clock, all logic on rising edge
// rst_n       in   1    synchronous reset, active low
// start       in   1    1-cycle request to begin a campaign; ignored unless IDLE
// ciphertext  in   128  ciphertext from the AES core under test
// fault_en    out  1    fault enable to the AES core
// fault_bit   out  7    fault position to the AES core
// out_valid   out  1    out_data/out_index/out_is_ref are valid
// out_ready   in   1    consumer accepts the record when out_valid && out_ready
// out_data    out  128  captured ciphertext
// out_index   out  7    fault_bit used for this record; 0 for the reference record
// out_is_ref  out  1    1 = fault-free reference record
// busy        out  1    1 in every state except IDLE and DONE
// done        out  1    1 in DONE; stays high until the next accepted start
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge) has priority over all else and is legal mid-campaign.
// - Reset values: state=IDLE, fault_en=0, fault_bit=0, out_valid=0, out_data=0, out_index=0, out_is_ref=0, busy=0, done=0, cnt=0.
// - cnt width = $clog2(max(BASELINE_CYCLES,SETTLE_CYCLES)+1); idx is 8 bits to avoid wrap at 128.
// - IDLE/DONE + start=1 -> BASE_WAIT: fault_en=0, cnt=0, done=0, busy=1.
// - BASE_WAIT: cnt increments each clock.
//   When cnt==BASELINE_CYCLES-1: out_data<=ciphertext, out_is_ref<=1, out_index<=0, out_valid<=1, next state BASE_SEND.
// - BASE_SEND: hold all out_* stable while out_valid && !out_ready.
//   On handshake: out_valid<=0, idx<=0, fault_bit<=0, fault_en<=1, cnt<=0, next state FLT_WAIT.
// - FLT_WAIT: fault_en=1 and fault_bit=idx[6:0], held constant; cnt increments each clock.
//   When cnt==SETTLE_CYCLES-1: out_data<=ciphertext, out_index<=idx, out_is_ref<=0, out_valid<=1, next state FLT_SEND.
// - Capture timing: ciphertext is sampled at the SETTLE_CYCLES-th rising edge after fault_bit first shows the new value.
// - FLT_SEND: fault_en/fault_bit stay unchanged while waiting for ready, so the core keeps seeing the same fault.
//   On handshake: out_valid<=0.
//   If idx==NUM_BITS-1: fault_en<=0, fault_bit<=0, next state DONE.
//   Otherwise: idx<=idx+1, fault_bit<=idx+1, cnt<=0, next state FLT_WAIT.
// - DONE: done=1, busy=0, fault_en=0. start re-enters BASE_WAIT the next cycle.
// - start while busy is ignored, with no effect on any counter or output.
// - out_valid never drops without a handshake, and the record never changes while valid is high.
// - out_ready is don't-care while out_valid=0.
// - Total records per campaign = NUM_BITS+1, always in order: reference record, then index 0..NUM_BITS-1.
// - Minimum campaign length, with out_ready tied 1: BASELINE_CYCLES + 1 + NUM_BITS*(SETTLE_CYCLES+1) clocks from start to done.
// TESTING
// 1) Reset: drive rst_n=0 for 2 clocks, with start=1 held -> all outputs 0, state IDLE, done=0 after release.
// 2) NUM_BITS=4, BASELINE=5, SETTLE=3, out_ready=1; ciphertext model = 128'hA5 ^ (fault_en<<fault_bit).
//    -> 5 records: ref=0xA5, then idx0..3 = 0xA4,0xA7,0xA1,0xAD.
//    -> done rises exactly 5+1+4*4=22 clocks after start.
// 3) Backpressure: same setup, out_ready=0 for 10 clocks on the idx1 record.
//    -> out_valid/out_data/out_index stable for all 10 clocks.
//    -> fault_bit stays 1 and fault_en stays 1; done is delayed by 10 clocks.
// 4) start pulsed during FLT_WAIT -> ignored; record count stays 5 and indices stay 0..3.
// 5) rst_n=0 one clock while in FLT_WAIT with idx=2 -> next clock fault_en=0, out_valid=0, busy=0.
//    A new start then begins again from the reference record.
// 6) Default params (128/100/20) with a random out_ready duty of 50%.
//    -> exactly 129 handshakes, indices 0..127 in order.
//    -> fault_bit sweeps to 7'h7F with no wrap; done=1 and fault_en=0 at the end.

Source files
------------

// File: rtl/fault_campaign_ctrl.sv
// rtl/fault_campaign_ctrl.sv - fault-injection campaign sequencer: one reference capture, then a sweep over the fault bits
// Each record is held on out_* until the consumer takes it; the fault stays applied while the record waits.
module fault_campaign_ctrl #(
  parameter int NUM_BITS        = 128,
  parameter int BASELINE_CYCLES = 100,
  parameter int SETTLE_CYCLES   = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] ciphertext,
  output logic         fault_en,
  output logic [6:0]   fault_bit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [6:0]   out_index,
  output logic         out_is_ref,
  output logic         busy,
  output logic         done
);

  localparam int CNT_MAX = (BASELINE_CYCLES > SETTLE_CYCLES) ? BASELINE_CYCLES : SETTLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] BASE_LAST   = CW'(BASELINE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]    LAST_IDX    = 8'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    BASE_WAIT,
    BASE_SEND,
    FLT_WAIT,
    FLT_SEND,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    idx;
  logic          hs;

  assign hs = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      fault_en   <= 1'b0;
      fault_bit  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      out_is_ref <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= BASE_WAIT;
            fault_en <= 1'b0;
            cnt      <= '0;
            done     <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BASE_WAIT: begin
          cnt <= cnt + CW'(1);
          if (cnt == BASE_LAST) begin
            out_data   <= ciphertext;
            out_is_ref <= 1'b1;
            out_index  <= '0;
            out_valid  <= 1'b1;
            state      <= BASE_SEND;
          end
        end
        BASE_SEND: begin
          if (hs) begin
            out_valid <= 1'b0;
            idx       <= '0;
            fault_bit <= '0;
            fault_en  <= 1'b1;
            cnt       <= '0;
            state     <= FLT_WAIT;
          end
        end
        FLT_WAIT: begin
          cnt <= cnt + CW'(1);
          if (cnt == SETTLE_LAST) begin
            out_data   <= ciphertext;
            out_index  <= idx[6:0];
            out_is_ref <= 1'b0;
            out_valid  <= 1'b1;
            state      <= FLT_SEND;
          end
        end
        FLT_SEND: begin
          if (hs) begin
            out_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              fault_en  <= 1'b0;
              fault_bit <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              idx       <= idx + 8'd1;
              fault_bit <= 7'(idx + 8'd1);
              cnt       <= '0;
              state     <= FLT_WAIT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// tb/tb_fault_campaign_ctrl.sv - self-checking bench: small-parameter scenario table plus a randomized full-size campaign
module tb_fault_campaign_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small instance: 4 bits, baseline 5, settle 3
  logic         rst_n_s, start_s, ready_s;
  logic [127:0] ct_s, data_s;
  logic         fault_en_s, valid_s, is_ref_s, busy_s, done_s;
  logic [6:0]   fault_bit_s, index_s;

  // default-parameter instance
  logic         rst_n_d, start_d, ready_d;
  logic [127:0] ct_d, data_d;
  logic         fault_en_d, valid_d, is_ref_d, busy_d, done_d;
  logic [6:0]   fault_bit_d, index_d;

  localparam logic [127:0] BASE_D = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  assign ct_s = 128'hA5 ^ ({127'b0, fault_en_s} << fault_bit_s);
  assign ct_d = BASE_D  ^ ({127'b0, fault_en_d} << fault_bit_d);

  fault_campaign_ctrl #(.NUM_BITS(4), .BASELINE_CYCLES(5), .SETTLE_CYCLES(3)) dut_s (
    .clk(clk), .rst_n(rst_n_s), .start(start_s), .ciphertext(ct_s),
    .fault_en(fault_en_s), .fault_bit(fault_bit_s), .out_valid(valid_s),
    .out_ready(ready_s), .out_data(data_s), .out_index(index_s),
    .out_is_ref(is_ref_s), .busy(busy_s), .done(done_s)
  );

  fault_campaign_ctrl dut_d (
    .clk(clk), .rst_n(rst_n_d), .start(start_d), .ciphertext(ct_d),
    .fault_en(fault_en_d), .fault_bit(fault_bit_d), .out_valid(valid_d),
    .out_ready(ready_d), .out_data(data_d), .out_index(index_d),
    .out_is_ref(is_ref_d), .busy(busy_d), .done(done_d)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected record k of a campaign: reference first, then bit k-1 flipped
  function automatic logic [127:0] exp_rec(input logic [127:0] base, input int k);
    logic [127:0] one;
    one = 128'd1;
    return (k == 0) ? base : (base ^ (one << (k - 1)));
  endfunction

  typedef struct {
    int stall_idx;
    int stall_len;
    int pulse_at;
    int exp_lat;
  } scen_t;

  task automatic run_small(input scen_t sc);
    int cyc, k, stalls;
    logic [127:0] hd;
    logic [6:0]   hi;
    cyc = 0; k = 0; stalls = 0; hd = '0; hi = '0;
    @(negedge clk) start_s = 1'b1;
    @(posedge clk);
    @(negedge clk) start_s = 1'b0;
    check("start_busy", 128'(busy_s), 128'd1);
    check("start_done_clr", 128'(done_s), 128'd0);
    while (!done_s && cyc < 200) begin
      if (valid_s && !is_ref_s && int'(index_s) == sc.stall_idx && stalls < sc.stall_len) begin
        if (stalls == 0) begin
          hd = data_s;
          hi = index_s;
        end else begin
          check("stall_data", data_s, hd);
          check("stall_index", 128'(index_s), 128'(hi));
        end
        check("stall_valid", 128'(valid_s), 128'd1);
        check("stall_fault_bit", 128'(fault_bit_s), 128'(sc.stall_idx));
        check("stall_fault_en", 128'(fault_en_s), 128'd1);
        ready_s = 1'b0;
        stalls++;
      end else begin
        ready_s = 1'b1;
        if (valid_s) begin
          check("rec_is_ref", 128'(is_ref_s), (k == 0) ? 128'd1 : 128'd0);
          check("rec_index", 128'(index_s), (k == 0) ? 128'd0 : 128'(k - 1));
          check("rec_data", data_s, exp_rec(128'hA5, k));
          k++;
        end
      end
      start_s = (cyc == sc.pulse_at);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    start_s = 1'b0;
    ready_s = 1'b1;
    check("campaign_done", 128'(done_s), 128'd1);
    check("done_latency", 128'(cyc), 128'(sc.exp_lat));
    check("record_count", 128'(k), 128'd5);
    check("end_fault_en", 128'(fault_en_s), 128'd0);
    check("end_busy", 128'(busy_s), 128'd0);
    repeat (3) @(negedge clk);
    check("done_held", 128'(done_s), 128'd1);
  endtask

  scen_t scen[5];

  initial begin
    int cyc, k, maxbit;
    logic pv, pr;
    logic [127:0] pd;
    logic [6:0]   pi;

    scen[0] = '{stall_idx: -1, stall_len: 0,  pulse_at: -1, exp_lat: 22};
    scen[1] = '{stall_idx: 1,  stall_len: 10, pulse_at: -1, exp_lat: 32};
    scen[2] = '{stall_idx: -1, stall_len: 0,  pulse_at: 8,  exp_lat: 22};
    scen[3] = '{stall_idx: 0,  stall_len: 3,  pulse_at: 14, exp_lat: 25};
    scen[4] = '{stall_idx: 3,  stall_len: 1,  pulse_at: -1, exp_lat: 23};

    // reset with start held high
    rst_n_s = 1'b0; start_s = 1'b1; ready_s = 1'b1;
    rst_n_d = 1'b0; start_d = 1'b0; ready_d = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_fault_en", 128'(fault_en_s), 128'd0);
    check("rst_fault_bit", 128'(fault_bit_s), 128'd0);
    check("rst_valid", 128'(valid_s), 128'd0);
    check("rst_data", data_s, 128'd0);
    check("rst_index", 128'(index_s), 128'd0);
    check("rst_is_ref", 128'(is_ref_s), 128'd0);
    check("rst_busy", 128'(busy_s), 128'd0);
    check("rst_done", 128'(done_s), 128'd0);
    rst_n_s = 1'b1; rst_n_d = 1'b1; start_s = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", 128'(busy_s), 128'd0);
    check("idle_done", 128'(done_s), 128'd0);
    check("idle_valid", 128'(valid_s), 128'd0);

    for (int i = 0; i < 5; i++) run_small(scen[i]);

    // reset in the middle of the idx2 settle window
    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    cyc = 0;
    while (!(fault_en_s && fault_bit_s == 7'd2 && !valid_s) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_idx2", 128'(cyc < 100), 128'd1);
    rst_n_s = 1'b0;
    @(negedge clk) rst_n_s = 1'b1;
    check("midrst_fault_en", 128'(fault_en_s), 128'd0);
    check("midrst_valid", 128'(valid_s), 128'd0);
    check("midrst_busy", 128'(busy_s), 128'd0);
    check("midrst_fault_bit", 128'(fault_bit_s), 128'd0);
    run_small(scen[0]);

    // full-size campaign under random backpressure
    @(negedge clk) start_d = 1'b1;
    @(negedge clk) start_d = 1'b0;
    cyc = 0; k = 0; maxbit = 0; pv = 1'b0; pr = 1'b0; pd = '0; pi = '0;
    while (!done_d && cyc < 20000) begin
      if (pv && !pr) begin
        check("bp_valid", 128'(valid_d), 128'd1);
        check("bp_data", data_d, pd);
        check("bp_index", 128'(index_d), 128'(pi));
      end
      if (int'(fault_bit_d) > maxbit) maxbit = int'(fault_bit_d);
      ready_d = 1'($urandom_range(0, 1));
      if (valid_d && ready_d) begin
        check("d_is_ref", 128'(is_ref_d), (k == 0) ? 128'd1 : 128'd0);
        check("d_index", 128'(index_d), (k == 0) ? 128'd0 : 128'(k - 1));
        check("d_data", data_d, exp_rec(BASE_D, k));
        if (k > 0) begin
          check("d_fault_bit", 128'(fault_bit_d), 128'(k - 1));
          check("d_fault_en", 128'(fault_en_d), 128'd1);
        end
        k++;
      end
      pv = valid_d; pr = ready_d; pd = data_d; pi = index_d;
      @(negedge clk);
      cyc++;
    end
    check("d_done", 128'(done_d), 128'd1);
    check("d_count", 128'(k), 128'd129);
    check("d_maxbit", 128'(maxbit), 128'd127);
    check("d_end_fault_en", 128'(fault_en_d), 128'd0);
    check("d_end_busy", 128'(busy_d), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
